// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle between control/register unit and muldiv_unit
interface muldiv_unit_if #(
  parameter int amount_of_bits = 32
);
  logic                      start;
  logic [2:0]                funct3;
  logic [amount_of_bits-1:0] ru_rs1;
  logic [amount_of_bits-1:0] ru_rs2;
  logic                      busy;
  logic                      done;
  logic [amount_of_bits-1:0] result;

  modport master (
    output start, funct3, ru_rs1, ru_rs2,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, ru_rs1, ru_rs2,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one result bit per clock
module muldiv_unit #(
  parameter int amount_of_bits = 32
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_unit_if.slave   bus
);
  localparam int N  = amount_of_bits;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [CW-1:0]   counter_q;
  logic [2*N-1:0]  prod_q;
  logic [N-1:0]    opnd_q;
  logic [N-1:0]    result_q;

  logic            a_sgn, b_sgn, sa, sb, neg_in;
  logic [N-1:0]    a_mag, b_mag;
  logic            div_zero, ovf, special;
  logic [N-1:0]    special_val;
  logic [N:0]      mul_sum, shifted, diff;
  logic [2*N-1:0]  mul_next, div_next, step, full;
  logic [N-1:0]    quo, rem, fixed;
  logic            last_iter;

  // Decode the incoming request: signedness, magnitudes and the special divide cases
  always_comb begin
    a_sgn    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
               (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    b_sgn    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    sa       = a_sgn & bus.ru_rs1[N-1];
    sb       = b_sgn & bus.ru_rs2[N-1];
    a_mag    = sa ? (~bus.ru_rs1 + N'(1)) : bus.ru_rs1;
    b_mag    = sb ? (~bus.ru_rs2 + N'(1)) : bus.ru_rs2;
    // Remainder follows the dividend sign; everything else uses the product/quotient sign
    neg_in   = (bus.funct3[2] && bus.funct3[1]) ? sa : (sa ^ sb);
    div_zero = bus.funct3[2] && (bus.ru_rs2 == '0);
    ovf      = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) &&
               (bus.ru_rs1 == {1'b1, {(N-1){1'b0}}}) && (bus.ru_rs2 == '1);
    special  = div_zero || ovf;
    if (div_zero) begin
      special_val = bus.funct3[1] ? bus.ru_rs1 : '1;
    end else begin
      special_val = bus.funct3[1] ? '0 : {1'b1, {(N-1){1'b0}}};
    end
  end

  // One iteration of shift-add multiply or restoring divide, plus the sign fix-up of its outcome
  always_comb begin
    // Multiply: upper half accumulates the multiplicand, lower half shifts the multiplier out
    mul_sum  = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, prod_q[N-1:1]};
    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in
    shifted  = {prod_q[2*N-1:N], prod_q[N-1]};
    diff     = shifted - {1'b0, opnd_q};
    if (!diff[N]) begin
      div_next = {diff[N-1:0], prod_q[N-2:0], 1'b1};
    end else begin
      div_next = {shifted[N-1:0], prod_q[N-2:0], 1'b0};
    end
    step     = op_q[2] ? div_next : mul_next;
    full     = neg_q ? (~step + (2*N)'(1)) : step;
    quo      = step[N-1:0];
    rem      = step[2*N-1:N];
    if (op_q[2]) begin
      if (op_q[1]) begin
        fixed = neg_q ? (~rem + N'(1)) : rem;
      end else begin
        fixed = neg_q ? (~quo + N'(1)) : quo;
      end
    end else begin
      fixed = (op_q[1:0] == 2'b00) ? full[N-1:0] : full[2*N-1:N];
    end
    last_iter = (counter_q == CW'(N-1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = special ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      neg_q     <= 1'b0;
      counter_q <= '0;
      prod_q    <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            op_q      <= bus.funct3;
            neg_q     <= neg_in;
            counter_q <= '0;
            if (special) begin
              result_q <= special_val;
            end else begin
              prod_q <= bus.funct3[2] ? {{N{1'b0}}, a_mag} : {{N{1'b0}}, b_mag};
              opnd_q <= bus.funct3[2] ? b_mag : a_mag;
            end
          end
        end
        RUN: begin
          prod_q    <= step;
          counter_q <= counter_q + CW'(1);
          if (last_iter) begin
            result_q <= fixed;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register unit and consumes the ru_rs1/ru_rs2 operand pair alongside the ALU.
- Computes one result bit per clock using shift-add (multiply) and restoring division (divide/remainder).
- Control stalls the mono-cycle PC while busy is high; the result is returned to the register-unit write mux (ru_data_wr) when done pulses.

Parameters:
- amount_of_bits, 32, operand and result width; iteration count equals amount_of_bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled on a rising clk edge
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- ru_rs1  input  amount_of_bits  operand A (multiplicand / dividend)
- ru_rs2  input  amount_of_bits  operand B (multiplier / divisor)
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; result valid
- result  output  amount_of_bits  last computed value

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, result=0, counter=0, all internal operand/accumulator registers 0. An operation in flight is abandoned; no done is produced for it.
- States: IDLE, RUN, DONE.
  - IDLE/DONE with start=1: latch funct3 and operands, go to RUN (counter=0). Special cases go straight to DONE instead (see below).
  - IDLE/DONE with start=0: go to or stay in IDLE.
  - RUN: one iteration per edge; after amount_of_bits iterations, go to DONE.
  - DONE lasts exactly one cycle.
- start while in RUN is ignored; operands and funct3 changing during RUN have no effect.
- Outputs:
  - busy = (state==RUN).
  - done = (state==DONE).
  - result is updated on the edge entering DONE and holds until the next DONE; it is not cleared by IDLE.
- Latency:
  - Normal operation: done high after amount_of_bits+1 edges from the edge that sampled start (33 at default).
  - Special case: done high after 1 edge.
  - Back-to-back: start=1 during DONE starts the next operation with no idle gap.
- Sign handling:
  - Signed operands are converted to magnitudes at latch time; iteration runs unsigned; the sign fix-up is applied when entering DONE.
  - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned. DIV/REM: both signed.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
- Multiply: full 2*amount_of_bits product. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- Division truncates toward zero.
- Special cases (resolved at latch, 1-edge latency):
  - Divisor 0: DIV/DIVU result = all ones; REM/REMU result = A.
  - Signed overflow (A = 0x80000000, B = 0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
  - Multiply has no special cases.
- Counter is $clog2(amount_of_bits)+1 bits wide and never wraps during RUN.

Test Plan:
- Reset then MUL 7 x 6: busy high for 32 cycles, done pulses once, result = 0x0000002A. Follow with MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MUL 0x80000000 x 2 -> 0x00000000.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- Divide by zero:
  - DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; done one edge after start, busy never high.
  - Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Start DIVU 100 / 7, then:
  - Pulse start with new operands at RUN cycle 10: ignored; result = 14 at the original latency.
  - Assert start during that DONE cycle with MUL 3 x 3: result 9 after 33 more edges.
- Start MUL 7 x 6, assert rst at RUN cycle 15 (asynchronous, mid-cycle): busy=0, done=0, result=0 immediately; no done pulse follows. A new MUL 2 x 3 then gives 6.
